// File: rtl/gp_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gp_timer                                                     |
// | Description : Memory-mapped general-purpose timer (bus responder at        |
// |               0x4000_02xx). Prescaled up-counter with auto-reload,         |
// |               one-shot mode, sticky update flag (UIF) and level IRQ.       |
// | Ports       : clk, reset (sync, active-high)                               |
// |               cs, wr, addr[31:0], wdata[31:0]  - slave write interface     |
// |               rdata[31:0]  - combinational read mux on addr[4:2]           |
// |               irq          - UIF & IE                                      |
// | Register map: 0x00 CTRL [0]EN [1]CLR(wo) [2]IE [3]ONESHOT                  |
// |               0x04 PSC  0x08 ARR  0x0C CNT  0x10 STAT [0]UIF (W1C)         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gp_timer #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_PSC  = 3'd1;
  localparam logic [2:0] OFF_ARR  = 3'd2;
  localparam logic [2:0] OFF_CNT  = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;

  logic             en;
  logic             ie;
  logic             oneshot;
  logic             uif;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] arr;
  logic [CNT_W-1:0] cnt;

  logic we;
  logic we_ctrl;
  logic we_psc;
  logic we_arr;
  logic we_cnt;
  logic we_stat;
  logic clr;
  logic cnt_load;
  logic tick;
  logic update;
  logic unused_bus;

  assign we      = cs && wr;
  assign we_ctrl = we && (addr[4:2] == OFF_CTRL);
  assign we_psc  = we && (addr[4:2] == OFF_PSC);
  assign we_arr  = we && (addr[4:2] == OFF_ARR);
  assign we_cnt  = we && (addr[4:2] == OFF_CNT);
  assign we_stat = we && (addr[4:2] == OFF_STAT);
  assign clr     = we_ctrl && wdata[1];

  // A software load of the counter (direct write or CLR) overrides any tick
  // landing on the same edge, so the tick cannot raise an update event.
  assign cnt_load = we_cnt || clr;
  assign tick     = en && (psc_cnt == psc);
  assign update   = tick && !cnt_load && (cnt == arr);

  // Only addr[4:2] is decoded and not every wdata bit lands in a register.
  assign unused_bus = ^{addr, wdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      oneshot <= 1'b0;
      uif     <= 1'b0;
      psc     <= '0;
      psc_cnt <= '0;
      arr     <= '1;
      cnt     <= '0;
    end else begin
      // A CTRL write takes precedence over the one-shot auto-disable.
      if (we_ctrl) begin
        en      <= wdata[0];
        ie      <= wdata[2];
        oneshot <= wdata[3];
      end else if (update && oneshot) begin
        en <= 1'b0;
      end

      if (we_psc) psc <= wdata[PSC_W-1:0];
      if (we_arr) arr <= wdata[CNT_W-1:0];

      // Prescaler restarts on any counter load or new divisor so the next
      // period is a full one.
      if (cnt_load || we_psc || tick) begin
        psc_cnt <= '0;
      end else if (en) begin
        psc_cnt <= psc_cnt + PSC_W'(1);
      end

      // Equality with ARR triggers the reload; if ARR was moved below CNT the
      // counter simply rolls over through all-ones to zero without an event.
      if (we_cnt) begin
        cnt <= wdata[CNT_W-1:0];
      end else if (clr || update) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Set has priority over a simultaneous write-1-to-clear.
      if (update) begin
        uif <= 1'b1;
      end else if (we_stat && wdata[0]) begin
        uif <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[4:2])
      OFF_CTRL: rdata = {28'd0, oneshot, ie, 1'b0, en};
      OFF_PSC:  rdata = 32'(psc);
      OFF_ARR:  rdata = 32'(arr);
      OFF_CNT:  rdata = 32'(cnt);
      OFF_STAT: rdata = {31'd0, uif};
      default:  rdata = '0;
    endcase
  end

  assign irq = uif && ie;

endmodule
`default_nettype wire
